usb_tx_bit_encoder: RTL and testbench

//  Transmit-side bit engine of the USB serial interface engine.
//  - Accepts control-tagged bytes from the packet layer; generates SYNC, LSB-first data bits, bit stuffing, NRZI encoding and EOP.
//  - Emits one line state per handshake to the wire driver, which paces bit timing.
//  - Control codes match the receive path: 0 = start of packet, 1 = end of packet, 2 = data, 3 = resume.

---
 rtl/usb_tx_bit_encoder_if.sv | 22 ++
 rtl/usb_tx_bit_encoder.sv | 237 +++++++++++++++++++++++
 tb/tb_usb_tx_bit_encoder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_bit_encoder_if.sv
// Byte-side and line-side handshake bundle of the USB transmit bit engine.
// The encoder takes the slave view; the packet layer / wire driver take the master view.
interface usb_tx_bit_encoder_if;
    logic [7:0] TxByteIn;
    logic [7:0] TxCtrlIn;
    logic       txByteWEn;
    logic       txByteRdy;
    logic [1:0] TxBitsOut;
    logic       TxOE;
    logic       txBitsWEn;
    logic       txBitsRdy;

    modport master (
        output TxByteIn, TxCtrlIn, txByteWEn, txBitsRdy,
        input  txByteRdy, TxBitsOut, TxOE, txBitsWEn
    );

    modport slave (
        input  TxByteIn, TxCtrlIn, txByteWEn, txBitsRdy,
        output txByteRdy, TxBitsOut, TxOE, txBitsWEn
    );
endinterface

// File: rtl/usb_tx_bit_encoder.sv
// USB transmit bit engine: SYNC, LSB-first data, bit stuffing, NRZI and EOP line states.
// Resume signalling (code 3) is built only when USB_TX_RESUME_EN is defined.
module usb_tx_bit_encoder #(
`ifdef USB_TX_RESUME_EN
    parameter logic [15:0] RESUME_BITS  = 16'd1000,
`endif
    parameter int          EOP_SE0_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] JBit,
    input  logic [1:0] KBit,
    usb_tx_bit_encoder_if.slave bus
);
    localparam logic [7:0] CTRL_SOP     = 8'd0;
    localparam logic [7:0] CTRL_DATA    = 8'd2;
    localparam logic [7:0] CTRL_RESUME  = 8'd3;
    localparam logic [7:0] SYNC_PATTERN = 8'h80;
    localparam logic [7:0] EOP_LAST     = 8'(EOP_SE0_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        WAIT_BYTE,
        DATA,
        EOP_SE0,
        EOP_J,
`ifdef USB_TX_RESUME_EN
        RESUME_K
`else
        DROP_BYTE
`endif
    } state_t;

    state_t     state, stateNext;
    logic [7:0] shiftReg;
    logic [3:0] bitCnt;
    logic [2:0] onesCnt;
    logic [2:0] onesAfter;
    logic [7:0] eopCnt;
    logic [1:0] lastLine;
    logic [1:0] lineOut;
    logic [1:0] txBitsOutR;
    logic       txBitsWEnR;
    logic       txOER;
    logic       wenPrev;
    logic       byteRdy;
    logic       byteTake;
    logic       canIssue;
    logic       issue;
    logic       isStuff;
    logic       stuffDue;
    logic       dataBit;
`ifdef USB_TX_RESUME_EN
    logic [15:0] resumeCnt;
`endif

    // NRZI: a 0 toggles between J and K, a 1 repeats the previous line state
    function automatic logic [1:0] nrzi(input logic b, input logic [1:0] last,
                                        input logic [1:0] j, input logic [1:0] k);
        if (b)
            nrzi = last;
        else
            nrzi = (last == j) ? k : j;
    endfunction

    // Driver readiness is not trusted during a pulse or the cycle after it
    assign canIssue  = bus.txBitsRdy && !txBitsWEnR && !wenPrev;
    assign byteTake  = bus.txByteWEn && byteRdy;
    assign stuffDue  = (onesCnt == 3'd6);
    assign dataBit   = shiftReg[0];
    assign onesAfter = (isStuff || !dataBit) ? 3'd0 : onesCnt + 3'd1;

    assign bus.txByteRdy = byteRdy;
    assign bus.TxBitsOut = txBitsOutR;
    assign bus.txBitsWEn = txBitsWEnR;
    assign bus.TxOE      = txOER;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (byteTake) begin
                    if (bus.TxCtrlIn == CTRL_SOP)
                        stateNext = SYNC;
`ifdef USB_TX_RESUME_EN
                    else if (bus.TxCtrlIn == CTRL_RESUME)
                        stateNext = RESUME_K;
`else
                    else if (bus.TxCtrlIn == CTRL_RESUME)
                        stateNext = DROP_BYTE;
`endif
                end
            end
            SYNC: begin
                if (issue && bitCnt == 4'd7)
                    stateNext = WAIT_BYTE;
            end
            WAIT_BYTE: begin
                if (byteTake)
                    stateNext = (bus.TxCtrlIn == CTRL_DATA) ? DATA : EOP_SE0;
            end
            DATA: begin
                // A byte ending on six ones holds here for its trailing stuff bit
                if (issue) begin
                    if (isStuff) begin
                        if (bitCnt == 4'd8)
                            stateNext = WAIT_BYTE;
                    end else if (bitCnt == 4'd7 && onesAfter != 3'd6) begin
                        stateNext = WAIT_BYTE;
                    end
                end
            end
            EOP_SE0: begin
                if (issue && !isStuff && eopCnt == EOP_LAST)
                    stateNext = EOP_J;
            end
            EOP_J: begin
                if (issue)
                    stateNext = IDLE;
            end
`ifdef USB_TX_RESUME_EN
            RESUME_K: begin
                if (issue && resumeCnt == RESUME_BITS - 16'd1)
                    stateNext = EOP_SE0;
            end
`else
            DROP_BYTE: stateNext = IDLE;
`endif
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        byteRdy = 1'b0;
        issue   = 1'b0;
        isStuff = 1'b0;
        lineOut = 2'b00;
        case (state)
            IDLE, WAIT_BYTE: byteRdy = 1'b1;
            SYNC: begin
                issue   = canIssue;
                lineOut = nrzi(dataBit, lastLine, JBit, KBit);
            end
            DATA: begin
                issue   = canIssue;
                isStuff = stuffDue;
                lineOut = nrzi(dataBit & ~stuffDue, lastLine, JBit, KBit);
            end
            EOP_SE0: begin
                issue   = canIssue;
                isStuff = stuffDue;
                lineOut = stuffDue ? nrzi(1'b0, lastLine, JBit, KBit) : 2'b00;
            end
            EOP_J: begin
                issue   = canIssue;
                lineOut = JBit;
            end
`ifdef USB_TX_RESUME_EN
            RESUME_K: begin
                issue   = canIssue;
                lineOut = KBit;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txBitsWEnR <= 1'b0;
            wenPrev    <= 1'b0;
            txOER      <= 1'b0;
            txBitsOutR <= 2'b00;
            lastLine   <= JBit;
            onesCnt    <= 3'd0;
            bitCnt     <= 4'd0;
            eopCnt     <= 8'd0;
        end else begin
            txBitsWEnR <= issue;
            wenPrev    <= txBitsWEnR;

            // TxOE rises with the first issued state and falls once back in IDLE
            if (issue) begin
                txBitsOutR <= lineOut;
                txOER      <= 1'b1;
            end else if (state == IDLE) begin
                txOER <= 1'b0;
            end

            if (issue && (state != EOP_SE0 || isStuff))
                lastLine <= lineOut;

            if (byteTake && state == IDLE) begin
                onesCnt  <= 3'd0;
                bitCnt   <= 4'd0;
                lastLine <= JBit;
            end else if (byteTake) begin
                bitCnt <= 4'd0;
            end else if (issue && (state == SYNC || state == DATA)) begin
                onesCnt <= onesAfter;
                if (!isStuff)
                    bitCnt <= bitCnt + 4'd1;
            end else if (issue && state == EOP_SE0 && isStuff) begin
                onesCnt <= 3'd0;
            end

            if (state != EOP_SE0)
                eopCnt <= 8'd0;
            else if (issue && !isStuff)
                eopCnt <= eopCnt + 8'd1;
        end
    end

`ifdef USB_TX_RESUME_EN
    always_ff @(posedge clk) begin
        if (rst || state != RESUME_K)
            resumeCnt <= 16'd0;
        else if (issue)
            resumeCnt <= resumeCnt + 16'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (byteTake)
            shiftReg <= (state == IDLE) ? SYNC_PATTERN : bus.TxByteIn;
        else if (issue && !isStuff)
            shiftReg <= {1'b0, shiftReg[7:1]};
    end
endmodule

// File: tb/tb_usb_tx_bit_encoder.sv
// Directed bench for usb_tx_bit_encoder: packets, stuffing cases, random driver readiness,
// resume / dropped codes and mid-packet reset.
module tb_usb_tx_bit_encoder;
    localparam logic [1:0] LJ = 2'b01;
    localparam logic [1:0] LK = 2'b10;
    localparam logic [1:0] LZ = 2'b00;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] JBit = LJ;
    logic [1:0] KBit = LK;
    bit         randMode = 1'b0;

    usb_tx_bit_encoder_if bus();

`ifdef USB_TX_RESUME_EN
    usb_tx_bit_encoder #(.RESUME_BITS(16'd4), .EOP_SE0_BITS(2)) dut (
        .clk(clk), .rst(rst), .JBit(JBit), .KBit(KBit), .bus(bus.slave));
`else
    usb_tx_bit_encoder #(.EOP_SE0_BITS(2)) dut (
        .clk(clk), .rst(rst), .JBit(JBit), .KBit(KBit), .bus(bus.slave));
`endif

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    logic [1:0] lineQ[$];
    logic       oeQ[$];
    logic       byteRdyQ[$];
    logic [1:0] expQ[$];
    int         backToBack = 0;
    int         rdyViol    = 0;
    bit         prevWen    = 1'b0;
    bit         prevRdy    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp)
            nPass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Line-state monitor; the decision cycle before each strobe must have seen rdy=1
    always @(negedge clk) begin
        if (bus.txBitsWEn) begin
            lineQ.push_back(bus.TxBitsOut);
            oeQ.push_back(bus.TxOE);
            byteRdyQ.push_back(bus.txByteRdy);
            if (prevWen) backToBack++;
            if (!prevRdy) rdyViol++;
        end
        prevWen = bus.txBitsWEn;
        prevRdy = bus.txBitsRdy;
    end

    initial begin
        bus.txBitsRdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.txBitsRdy = randMode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic pushStr(input string s);
        for (int i = 0; i < s.len(); i++)
            expQ.push_back(s[i] == "J" ? LJ : (s[i] == "K" ? LK : LZ));
    endtask

    task automatic sendByte(input logic [7:0] ctrl, input logic [7:0] data);
        int n = 0;
        while (!bus.txByteRdy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("byteRdy wait", bus.txByteRdy, 1);
        bus.TxCtrlIn  = ctrl;
        bus.TxByteIn  = data;
        bus.txByteWEn = 1'b1;
        @(negedge clk);
        bus.txByteWEn = 1'b0;
    endtask

    task automatic waitStrobes(input int target);
        int n = 0;
        while (lineQ.size() < target && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        chk("strobe count", lineQ.size(), target);
    endtask

    task automatic checkSeq(input string tag, input int base);
        for (int i = 0; i < expQ.size(); i++) begin
            chk($sformatf("%s line%0d", tag, i),
                (base + i < lineQ.size()) ? lineQ[base + i] : 2'bxx, expQ[i]);
            chk($sformatf("%s oe%0d", tag, i),
                (base + i < oeQ.size()) ? oeQ[base + i] : 1'bx, 1);
        end
        chk({tag, " oe after"}, bus.TxOE, 0);
        chk({tag, " byteRdy after"}, bus.txByteRdy, 1);
    endtask

    task automatic runPacket(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input int nBytes, input string dataExp);
        int base = lineQ.size();
        expQ.delete();
        pushStr("KJKJKJKK");
        pushStr(dataExp);
        pushStr("00J");
        sendByte(8'd0, 8'h00);
        if (nBytes > 0) sendByte(8'd2, b0);
        if (nBytes > 1) sendByte(8'd2, b1);
        sendByte(8'd1, 8'h00);
        waitStrobes(base + expQ.size());
        checkSeq(tag, base);
    endtask

    initial begin
        int base;
        rst           = 1'b1;
        bus.TxByteIn  = 8'h00;
        bus.TxCtrlIn  = 8'h00;
        bus.txByteWEn = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset byteRdy", bus.txByteRdy, 1);
        chk("reset wen", bus.txBitsWEn, 0);
        chk("reset bits", bus.TxBitsOut, 2'b00);
        chk("reset oe", bus.TxOE, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        runPacket("d00", 8'h00, 8'h00, 1, "JKJKJKJK");
        runPacket("dFF", 8'hFF, 8'h00, 1, "KKKKKJJJJ");
        runPacket("d3F", 8'h3F, 8'h00, 1, "KKKKKJJKJ");

        // Trailing stuff: byteRdy low at the 8th data bit, high with the stuffed bit
        base = lineQ.size();
        runPacket("dFC", 8'hFC, 8'h00, 1, "JKKKKKKKJ");
        chk("dFC rdy at bit8", byteRdyQ[base + 15], 0);
        chk("dFC rdy at stuff", byteRdyQ[base + 16], 1);

        runPacket("d80_1F", 8'h80, 8'h1F, 2, "JKJKJKJJJJJJJKJKJ");

        randMode = 1'b1;
        runPacket("rand", 8'h80, 8'h1F, 2, "JKJKJKJJJJJJJKJKJ");
        randMode = 1'b0;
        repeat (3) @(negedge clk);
        chk("back-to-back strobes", backToBack, 0);
        chk("strobe without rdy", rdyViol, 0);

        // Code 2 in IDLE is dropped
        base = lineQ.size();
        sendByte(8'd2, 8'hA5);
        chk("drop data rdy", bus.txByteRdy, 1);
        repeat (20) @(negedge clk);
        chk("drop data strobes", lineQ.size(), base);

        base = lineQ.size();
`ifdef USB_TX_RESUME_EN
        expQ.delete();
        pushStr("KKKK00J");
        sendByte(8'd3, 8'h00);
        waitStrobes(base + 7);
        checkSeq("resume", base);
`else
        sendByte(8'd3, 8'h00);
        chk("resume drop rdy low", bus.txByteRdy, 0);
        @(negedge clk);
        chk("resume drop rdy back", bus.txByteRdy, 1);
        repeat (20) @(negedge clk);
        chk("resume drop strobes", lineQ.size(), base);
        chk("resume drop oe", bus.TxOE, 0);
`endif

        // Reset while the 4th data bit is pending
        base = lineQ.size();
        sendByte(8'd0, 8'h00);
        sendByte(8'd2, 8'h00);
        for (int n = 0; n < 1000 && lineQ.size() < base + 11; n++) @(negedge clk);
        chk("pre-reset strobes", lineQ.size(), base + 11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst oe", bus.TxOE, 0);
        chk("midrst byteRdy", bus.txByteRdy, 1);
        chk("midrst wen", bus.txBitsWEn, 0);
        chk("midrst bits", bus.TxBitsOut, 2'b00);
        repeat (20) @(negedge clk);
        chk("midrst no EOP", lineQ.size(), base + 11);
        runPacket("after rst", 8'h00, 8'h00, 1, "JKJKJKJK");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
